mlp_seq_ctrl: RTL

Sequencer that feeds the combinational Pendigits MLP (`top`: 16×4-bit `inp` in, 4-bit class `out`) from a serial feature stream. It collects NUM_A features over a valid/ready port, holds the packed vector stable for a programmable settle window sized to the printed-circuit propagation delay, then captures the class index and offers it on a valid/ready result port. It sits between the sample source (ADC/sensor FIFO) and the MLP instance, replacing the fixed-delay stimulus loop used in simulation.

---
 rtl/mlp_seq_ctrl.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/mlp_seq_ctrl.sv
// -----------------------------------------------------------------------------
// mlp_seq_ctrl
//
// Sequencer in front of the combinational Pendigits MLP. Features arrive one
// at a time over a valid/ready port and are packed into the MLP input vector.
// Once a full sample is loaded the vector is held for a programmable settle
// window so the MLP output can propagate, then the class index is captured and
// offered on a valid/ready result port. The next sample is only accepted after
// the result has been consumed.
//
// Parameters
//   NUM_A    : features per sample
//   WIDTH_A  : bits per feature
//   OUTWIDTH : bits of MLP class index
//   SETTLE   : cycles the vector is held before mlp_out is sampled (>= 1)
//   CNT_W    : width of the completed-result counter (MLP_SEQ_CNT_EN only)
//
// Optional feature
//   MLP_SEQ_CNT_EN : when defined, adds the sample_cnt output, a wrapping count
//                    of result handshakes (cleared only by rst).
//
// Ports
//   clk, rst            : clock, asynchronous active-high reset
//   flush               : synchronous abort of the current sample
//   in_valid/in_data    : feature stream in; in_ready high only while loading
//   inp                 : packed vector to MLP, feature i at bits
//                         [(i+1)*WIDTH_A-1 : i*WIDTH_A]
//   mlp_out             : class index returned by the MLP
//   res_valid/res_data  : captured class index out; res_ready from consumer
//   busy                : high unless idle in LOAD with slot index 0
//   sample_cnt          : completed-result count (MLP_SEQ_CNT_EN only)
// -----------------------------------------------------------------------------
module mlp_seq_ctrl #(
  parameter int NUM_A    = 16,
  parameter int WIDTH_A  = 4,
  parameter int OUTWIDTH = 4,
  parameter int SETTLE   = 8
`ifdef MLP_SEQ_CNT_EN
  ,
  parameter int CNT_W    = 16
`endif
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [WIDTH_A-1:0]         in_data,
  output logic                       in_ready,
  output logic [NUM_A*WIDTH_A-1:0]   inp,
  input  logic [OUTWIDTH-1:0]        mlp_out,
  output logic                       res_valid,
  output logic [OUTWIDTH-1:0]        res_data,
  input  logic                       res_ready,
  output logic                       busy
`ifdef MLP_SEQ_CNT_EN
  ,
  output logic [CNT_W-1:0]           sample_cnt
`endif
);

  localparam int IDX_W = (NUM_A  > 1) ? $clog2(NUM_A)  : 1;
  localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_A - 1);
  localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE - 1);

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t                     r_state;
  state_t                     w_next_state;

  logic [IDX_W-1:0]           r_idx;
  logic [SET_W-1:0]           r_settle;
  logic [NUM_A*WIDTH_A-1:0]   r_inp;
  logic [OUTWIDTH-1:0]        r_res_data;

  logic                       w_accept;   // feature written this cycle
  logic                       w_last;     // accept of the final slot
  logic                       w_capture;  // sample mlp_out this cycle
  logic                       w_res_hs;   // result consumed this cycle

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, matching the hardware.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_LOAD;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and handshake decode
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_last       = 1'b0;
    w_capture    = 1'b0;
    w_res_hs     = 1'b0;
    in_ready     = 1'b0;
    res_valid    = 1'b0;

    unique case (r_state)
      ST_LOAD: begin
        in_ready = 1'b1;
        // A feature arriving together with flush is dropped.
        w_accept = in_valid & ~flush;
        if (w_accept && (r_idx == LAST_IDX)) begin
          w_last       = 1'b1;
          w_next_state = ST_SETTLE;
        end
      end

      ST_SETTLE: begin
        if (r_settle == '0) begin
          w_capture    = ~flush;
          w_next_state = ST_DONE;
        end
      end

      ST_DONE: begin
        res_valid = 1'b1;
        if (res_ready) begin
          w_res_hs     = ~flush;
          w_next_state = ST_LOAD;
        end
      end

      default: begin
        w_next_state = ST_LOAD;
      end
    endcase

    // Flush overrides every transition, including a coincident handshake.
    if (flush) begin
      w_next_state = ST_LOAD;
    end
  end

  // Idle means waiting for the first feature of a fresh sample.
  assign busy = !((r_state == ST_LOAD) && (r_idx == '0));

  // ---------------------------------------------------------------------------
  // Datapath: slot index, settle counter, packed vector, result register
  // ---------------------------------------------------------------------------
  // NOTE: the packed vector is a plain register bank, not a RAM, and is reset
  // because the MLP input must read as zero straight out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx      <= '0;
      r_settle   <= '0;
      r_inp      <= '0;
      r_res_data <= '0;
    end else if (flush) begin
      // Vector and last result are deliberately kept across a flush.
      r_idx    <= '0;
      r_settle <= '0;
    end else begin
      if (w_accept) begin
        for (int i = 0; i < NUM_A; i++) begin
          if (r_idx == IDX_W'(i)) begin
            r_inp[i*WIDTH_A +: WIDTH_A] <= in_data;
          end
        end
        r_idx <= w_last ? '0 : r_idx + 1'b1;
      end

      // Loading SETTLE-1 and capturing on the zero cycle places the capture
      // exactly SETTLE edges after the final accept.
      if (w_last) begin
        r_settle <= SETTLE_LOAD;
      end else if ((r_state == ST_SETTLE) && (r_settle != '0)) begin
        r_settle <= r_settle - 1'b1;
      end

      if (w_capture) begin
        r_res_data <= mlp_out;
      end
    end
  end

  assign inp      = r_inp;
  assign res_data = r_res_data;

`ifdef MLP_SEQ_CNT_EN
  // ---------------------------------------------------------------------------
  // Completed-result counter; wraps naturally, unaffected by flush.
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] r_sample_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sample_cnt <= '0;
    end else if (w_res_hs) begin
      r_sample_cnt <= r_sample_cnt + 1'b1;
    end
  end

  assign sample_cnt = r_sample_cnt;
`endif

endmodule
